// File: rtl/jtopl_ch_bank.sv
// jtopl_ch_bank: per-channel OPL register bank (9 x BANKS channels).
// Presents fnum/block/keyon/fb/con/outen in operator-slot order, supports
// 4-op channel pairing, rhythm key-on override and a req/ack write port
// that commits when the addressed channel's modulator slot passes.
module jtopl_ch_bank #(
  parameter int BANKS    = 2,
  parameter int OPL_TYPE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr_req,
  input  logic [1:0] wr_reg,
  input  logic       wr_bank,
  input  logic [3:0] wr_ch,
  input  logic [7:0] din,
  output logic       busy,
  output logic       wr_ack,
  input  logic       rhy_en,
  input  logic [4:0] rhy_kon,
  output logic       zero,
  output logic       bank,
  output logic [1:0] group,
  output logic [2:0] sub,
  output logic       op,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic       keyon_I,
  output logic [2:0] fb_I,
  output logic       con_I,
  output logic [3:0] outen_I,
  output logic       four_op_I,
  output logic       four_op_sec_I
);

  localparam int NCH = 9 * BANKS;

  typedef enum logic [1:0] {
    REG_A0   = 2'd0,
    REG_B0   = 2'd1,
    REG_C0   = 2'd2,
    REG_MASK = 2'd3
  } wr_reg_e;

  // Slot counter and registered rhythm enable
  logic       bank_q;
  logic [1:0] group_q;
  logic [2:0] sub_q;
  logic       rhy_en_q;

  // Channel memory, 4-op mask and 4-op holding registers
  logic [9:0]  fnum_q  [NCH];
  logic [2:0]  block_q [NCH];
  logic        kon_q   [NCH];
  logic [2:0]  fb_q    [NCH];
  logic        con_q   [NCH];
  logic [3:0]  outen_q [NCH];
  logic [5:0]  mask_q;
  logic [13:0] hold_q  [3];   // {kon, block, fnum} of primary channel 0..2

  // Write-port holding registers
  logic       busy_q, ack_q;
  wr_reg_e    wreg_q;
  logic       wbank_q;
  logic [3:0] wch_q;
  logic [7:0] wdin_q;

  // Current slot decode
  logic       cur_op;
  logic [2:0] sub_mod;
  logic [3:0] cur_ch;
  logic [4:0] cur_idx;
  logic [1:0] pair_c;
  logic [2:0] mask_idx;
  logic [7:0] mask_ext;

  assign cur_op   = (sub_q >= 3'd3);
  assign sub_mod  = cur_op ? (sub_q - 3'd3) : sub_q;
  assign cur_ch   = ({2'b00, group_q} * 4'd3) + {1'b0, sub_mod};
  assign cur_idx  = (bank_q ? 5'd9 : 5'd0) + {1'b0, cur_ch};
  assign pair_c   = (cur_ch < 4'd3) ? cur_ch[1:0] : 2'(cur_ch - 4'd3);
  assign mask_idx = (bank_q ? 3'd3 : 3'd0) + {1'b0, pair_c};
  assign mask_ext = {2'b00, mask_q};

  // Write request decode
  logic       w_valid;
  logic [4:0] w_idx;
  logic       commit_ch;
  logic       retire;

  assign w_valid   = (wch_q <= 4'd8) && ((BANKS > 1) || !wbank_q);
  assign w_idx     = (wbank_q ? 5'd9 : 5'd0) + {1'b0, wch_q};
  assign commit_ch = busy_q && w_valid && (wreg_q != REG_MASK) && cen &&
                     (bank_q == wbank_q) && (cur_ch == wch_q) && !cur_op;
  assign retire    = busy_q && ((wreg_q == REG_MASK) || !w_valid || commit_ch);

  // Slot counter: sub 0..5, group 0..2, bank 0..BANKS-1; rhythm enable sampled per slot
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q   <= 1'b0;
      group_q  <= 2'd0;
      sub_q    <= 3'd0;
      rhy_en_q <= 1'b0;
    end else if (cen) begin
      rhy_en_q <= rhy_en;
      if (sub_q == 3'd5) begin
        sub_q <= 3'd0;
        if (group_q == 2'd2) begin
          group_q <= 2'd0;
          bank_q  <= (bank_q == 1'(BANKS - 1)) ? 1'b0 : ~bank_q;
        end else begin
          group_q <= group_q + 2'd1;
        end
      end else begin
        sub_q <= sub_q + 3'd1;
      end
    end
  end

  // Write handshake: latch request, retire on matching slot (or at once for mask/invalid)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      wreg_q  <= REG_A0;
      wbank_q <= 1'b0;
      wch_q   <= 4'd0;
      wdin_q  <= 8'd0;
      mask_q  <= 6'd0;
    end else begin
      ack_q <= 1'b0;
      if (!busy_q) begin
        if (wr_req) begin
          busy_q  <= 1'b1;
          wreg_q  <= wr_reg_e'(wr_reg);
          wbank_q <= wr_bank;
          wch_q   <= wr_ch;
          wdin_q  <= din;
        end
      end else if (retire) begin
        busy_q <= 1'b0;
        ack_q  <= 1'b1;
        if (wreg_q == REG_MASK) mask_q <= wdin_q[5:0];
      end
    end
  end

  // Channel memory write on commit
  // NOTE: the channel memory is flop-based and cleared on reset, so no RAM macro is inferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        fnum_q[i]  <= 10'd0;
        block_q[i] <= 3'd0;
        kon_q[i]   <= 1'b0;
        fb_q[i]    <= 3'd0;
        con_q[i]   <= 1'b0;
        outen_q[i] <= 4'd0;
      end
    end else if (commit_ch) begin
      case (wreg_q)
        REG_A0: fnum_q[w_idx][7:0] <= wdin_q;
        REG_B0: begin
          kon_q[w_idx]       <= wdin_q[5];
          block_q[w_idx]     <= wdin_q[4:2];
          fnum_q[w_idx][9:8] <= wdin_q[1:0];
        end
        REG_C0: begin
          outen_q[w_idx] <= wdin_q[7:4];
          fb_q[w_idx]    <= wdin_q[3:1];
          con_q[w_idx]   <= wdin_q[0];
        end
        default: ;
      endcase
    end
  end

  // Capture primary channel pitch/key-on on its carrier slot for the paired secondary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) hold_q[i] <= 14'd0;
    end else if (cen && cur_op && (cur_ch < 4'd3)) begin
      hold_q[cur_ch[1:0]] <= {kon_q[cur_idx], block_q[cur_idx], fnum_q[cur_idx]};
    end
  end

  // Output mux: memory head, 4-op substitution, rhythm override
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    fnum_I        = fnum_q[cur_idx];
    block_I       = block_q[cur_idx];
    keyon_I       = kon_q[cur_idx];
    fb_I          = fb_q[cur_idx];
    con_I         = con_q[cur_idx];
    outen_I       = (OPL_TYPE == 3) ? outen_q[cur_idx] : 4'hF;
    four_op_I     = 1'b0;
    four_op_sec_I = 1'b0;
    if ((OPL_TYPE == 3) && (cur_ch < 4'd6) && mask_ext[mask_idx]) begin
      four_op_I = 1'b1;
      if (cur_ch >= 4'd3) begin
        four_op_sec_I               = 1'b1;
        {keyon_I, block_I, fnum_I}  = hold_q[pair_c];
      end
    end
    if (rhy_en_q && !bank_q) begin
      case (cur_ch)
        4'd6: keyon_I = rhy_kon[4];
        4'd7: begin
          keyon_I = cur_op ? rhy_kon[3] : rhy_kon[0];
          con_I   = 1'b1;
        end
        4'd8: begin
          keyon_I = cur_op ? rhy_kon[1] : rhy_kon[2];
          con_I   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign wr_ack = ack_q;
  assign zero   = !bank_q && (group_q == 2'd0) && (sub_q == 3'd0);
  assign bank   = bank_q;
  assign group  = group_q;
  assign sub    = sub_q;
  assign op     = cur_op;

endmodule

// File: tb/tb_jtopl_ch_bank.sv
// Directed testbench for jtopl_ch_bank (BANKS=2, OPL_TYPE=3).
module tb_jtopl_ch_bank;

  logic       clk = 1'b0;
  logic       rst, cen, wr_req, wr_bank;
  logic [1:0] wr_reg;
  logic [3:0] wr_ch;
  logic [7:0] din;
  logic       busy, wr_ack, rhy_en;
  logic [4:0] rhy_kon;
  logic       zero, bank, op;
  logic [1:0] group;
  logic [2:0] sub;
  logic [9:0] fnum_I;
  logic [2:0] block_I, fb_I;
  logic       keyon_I, con_I, four_op_I, four_op_sec_I;
  logic [3:0] outen_I;

  int total = 0;
  int bad   = 0;

  jtopl_ch_bank #(.BANKS(2), .OPL_TYPE(3)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .wr_req(wr_req), .wr_reg(wr_reg), .wr_bank(wr_bank), .wr_ch(wr_ch), .din(din),
    .busy(busy), .wr_ack(wr_ack),
    .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .zero(zero), .bank(bank), .group(group), .sub(sub), .op(op),
    .fnum_I(fnum_I), .block_I(block_I), .keyon_I(keyon_I), .fb_I(fb_I), .con_I(con_I),
    .outen_I(outen_I), .four_op_I(four_op_I), .four_op_sec_I(four_op_sec_I)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the DUT presents (bank b, channel ch, op o)
  task automatic goto_slot(input logic b, input int ch, input logic o);
    int n = 0;
    while (!(bank == b && group == 2'(ch / 3) && sub == 3'(3 * o + ch % 3)) && n < 60) begin
      tick();
      n++;
    end
    check("goto_slot", {bank, group, sub}, {b, 2'(ch / 3), 3'(3 * o + ch % 3)});
  endtask

  // Issue one request and wait (bounded) for its ack; lat = clocks from busy to ack
  task automatic do_write(input logic [1:0] r, input logic b, input logic [3:0] ch,
                          input logic [7:0] d, output int lat);
    wr_reg = r; wr_bank = b; wr_ch = ch; din = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("busy_set", busy, 1);
    lat = 0;
    while (!wr_ack && lat < 40) begin
      tick();
      lat++;
    end
    check("ack_seen", wr_ack, 1);
    check("busy_at_ack", busy, 0);
  endtask

  initial begin
    int lat, acks;
    rst = 1'b0; cen = 1'b0; wr_req = 1'b0; wr_reg = 2'd0; wr_bank = 1'b0;
    wr_ch = 4'd0; din = 8'd0; rhy_en = 1'b0; rhy_kon = 5'd0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_zero", zero, 1);

    // Slot sequence over one full frame plus one
    rst = 1'b1;
    cen = 1'b1;
    for (int i = 0; i <= 36; i++) begin
      check("seq_zero", zero, (i % 36) == 0);
      check("seq_bank", bank, (i % 36) >= 18);
      check("seq_grp_sub", {group, sub}, {2'((i / 6) % 3), 3'(i % 6)});
      check("seq_data", {fnum_I, block_I, keyon_I, fb_I, con_I, outen_I, four_op_I, four_op_sec_I}, 0);
      tick();
    end
    // Counter holds while cen is low
    cen = 1'b0;
    repeat (3) tick();
    check("stall_sub", sub, 3'd1);
    cen = 1'b1;

    // B0 write to bank1 ch4: kon=1, block=3, fnum hi=01
    do_write(2'd1, 1'b1, 4'd4, 8'h2D, lat);
    check("b0_lat_le36", lat <= 36, 1);
    check("b0_commit_slot", {bank, group, sub}, {1'b1, 2'd1, 3'd2});
    tick();
    check("b0_ack_pulse", wr_ack, 0);
    goto_slot(1'b1, 4, 1'b0);
    check("b0_kon", keyon_I, 1);
    check("b0_block", block_I, 3'd3);
    check("b0_fnum", fnum_I, 10'h100);
    goto_slot(1'b1, 4, 1'b1);
    check("b0_kon_op1", keyon_I, 1);
    goto_slot(1'b0, 4, 1'b0);
    check("b0_other_bank", keyon_I, 0);

    // Four-op pair ch0/ch3 of bank 0
    do_write(2'd3, 1'b0, 4'd0, 8'h01, lat);
    check("mask_lat", lat, 1);
    do_write(2'd0, 1'b0, 4'd0, 8'h55, lat);
    do_write(2'd1, 1'b0, 4'd0, 8'h35, lat);
    do_write(2'd0, 1'b0, 4'd3, 8'h00, lat);
    do_write(2'd2, 1'b0, 4'd3, 8'h5B, lat);
    goto_slot(1'b0, 0, 1'b0);
    check("pri_four", {four_op_I, four_op_sec_I}, 2'b10);
    check("pri_fnum", fnum_I, 10'h155);
    goto_slot(1'b0, 3, 1'b0);
    check("sec_four", {four_op_I, four_op_sec_I}, 2'b11);
    check("sec_fnum", fnum_I, 10'h155);
    check("sec_block", block_I, 3'd5);
    check("sec_kon", keyon_I, 1);
    check("sec_fb_con", {fb_I, con_I}, {3'd5, 1'b1});
    check("sec_outen", outen_I, 4'h5);
    goto_slot(1'b0, 1, 1'b0);
    check("unpaired_ch1", four_op_I, 0);
    goto_slot(1'b1, 3, 1'b0);
    check("unpaired_b1ch3", four_op_I, 0);

    // Rhythm: SD and HH keyed
    rhy_en = 1'b1; rhy_kon = 5'b01001;
    tick();
    goto_slot(1'b0, 6, 1'b0);
    check("rhy_ch6_op0", {keyon_I, con_I}, 2'b00);
    goto_slot(1'b0, 6, 1'b1);
    check("rhy_ch6_op1", keyon_I, 0);
    goto_slot(1'b0, 7, 1'b0);
    check("rhy_ch7_op0", {keyon_I, con_I}, 2'b11);
    goto_slot(1'b0, 7, 1'b1);
    check("rhy_ch7_op1", {keyon_I, con_I}, 2'b11);
    goto_slot(1'b0, 8, 1'b0);
    check("rhy_ch8_op0", {keyon_I, con_I}, 2'b01);
    goto_slot(1'b0, 8, 1'b1);
    check("rhy_ch8_op1", keyon_I, 0);
    goto_slot(1'b1, 7, 1'b0);
    check("rhy_bank1_ch7", {keyon_I, con_I}, 2'b00);
    rhy_en = 1'b0; rhy_kon = 5'd0;

    // Out-of-range channel: immediate ack, no state change
    do_write(2'd1, 1'b0, 4'd12, 8'hFF, lat);
    check("bad_ch_lat", lat, 1);
    goto_slot(1'b1, 3, 1'b0);
    check("bad_ch_nochange", {keyon_I, block_I, fnum_I}, 0);

    // Second request while busy is ignored
    wr_reg = 2'd0; wr_bank = 1'b1; wr_ch = 4'd8; din = 8'h11; wr_req = 1'b1;
    tick();
    check("busy2_set", busy, 1);
    wr_ch = 4'd5; din = 8'h77;
    tick();
    wr_req = 1'b0;
    acks = 0;
    for (int n = 0; n < 80; n++) begin
      if (wr_ack) acks++;
      tick();
    end
    check("busy2_acks", acks, 1);
    goto_slot(1'b1, 8, 1'b0);
    check("busy2_first", fnum_I, 10'h011);
    goto_slot(1'b1, 5, 1'b0);
    check("busy2_second_ignored", fnum_I, 10'h000);

    // Reset with a write pending
    wr_reg = 2'd1; wr_bank = 1'b1; wr_ch = 4'd8; din = 8'h20; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("rst_pend_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_pend_busy_clr", busy, 0);
    check("rst_pend_zero", zero, 1);
    repeat (2) tick();
    rst = 1'b1;
    acks = 0;
    for (int n = 0; n < 40; n++) begin
      if (wr_ack || busy) acks++;
      tick();
    end
    check("rst_pend_no_ack", acks, 0);
    goto_slot(1'b1, 8, 1'b0);
    check("rst_mem_clr", {keyon_I, fnum_I}, 0);
    goto_slot(1'b0, 0, 1'b0);
    check("rst_mask_clr", {four_op_I, fnum_I}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtopl_ch_bank.md
Name: jtopl_ch_bank

Overview:
- Parametrised successor of the OPL channel register block. Holds per-channel settings for 9×BANKS channels: fnum, block, key-on, feedback, connection and output enables.
- Presents these settings time-multiplexed in operator-slot order for the PG/EG/OP pipeline.
- Adds features the OPL2 block lacks: a second register bank (OPL3), 4-operator channel pairing, and a req/ack write handshake that commits when the target channel's slot passes.

Parameters:
- BANKS, 2, number of 9-channel banks. 1 = OPL/OPL2 timing, 2 = OPL3.
- OPL_TYPE, 3, 1/2 = fnum/fb/con only (outen_I forced to 4'b1111, four-op disabled); 3 = output enables and four-op active.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; one slot advance per cen
- wr_req  in  1  write request, sampled only when busy=0
- wr_reg  in  2  0=fnum low (A0), 1=kon/block/fnum hi (B0), 2=fb/con/outen (C0), 3=four-op mask (104h)
- wr_bank  in  1  target bank
- wr_ch  in  4  target channel 0..8
- din  in  8  write data
- busy  out  1  write pending
- wr_ack  out  1  one-clk pulse when a request retires
- rhy_en  in  1  rhythm mode (bank 0 only)
- rhy_kon  in  5  {BD,SD,TOM,CY,HH} key-on
- zero  out  1  high during slot 0 of bank 0
- bank  out  1  current bank
- group  out  2  0..2
- sub  out  3  0..5
- op  out  1  0 = modulator (sub 0..2), 1 = carrier (sub 3..5)
- fnum_I  out  10
- block_I  out  3
- keyon_I  out  1
- fb_I  out  3
- con_I  out  1
- outen_I  out  4  {D,C,B,A}
- four_op_I  out  1  current channel is part of an enabled 4-op pair
- four_op_sec_I  out  1  current channel is the secondary (ch+3) of a pair

Behaviour:
- Slot counter: sub 0..5, then group 0..2, then bank 0..BANKS-1. Advances on cen only; 18×BANKS slots per frame, then wraps to 0.
- Current channel = group*3 + (sub mod 3). Outputs are combinational from the head of the per-channel shift memory and valid in the same cycle as group/sub/op.
- Reset (async, rst=0):
  - Counter to slot 0, bank 0, so zero=1.
  - All channel memory, the 4-op mask and the holding registers cleared.
  - busy=0, wr_ack=0.
  - A pending write is dropped with no ack.
- Handshake:
  - wr_req with busy=0 latches wr_reg/wr_bank/wr_ch/din and sets busy next clk.
  - A channel write commits on the cen where bank/channel match and op=0.
  - On that same clk: busy falls and wr_ack pulses. Worst-case latency is 18×BANKS cen cycles.
  - wr_reg=3 commits on the next clk regardless of slot; din[5:0] goes to the mask, bits 0..2 for bank 0 pairs and bits 3..5 for bank 1.
  - wr_ch>8, or wr_bank=1 when BANKS=1: ack on the next clk, no state change.
  - wr_req while busy=1 is ignored.
- Field mapping:
  - A0: fnum[7:0].
  - B0: din[5]=kon, din[4:2]=block, din[1:0]=fnum[9:8].
  - C0: din[3:1]=fb, din[0]=con, din[7:4]=outen.
- Four-op, OPL_TYPE=3 only:
  - If mask bit for (bank, c) is set, c in 0..2, then channel c outputs four_op_I=1.
  - On its op=1 slot, c's fnum/block/kon are captured into a 3-entry holding register.
  - Channel c+3 then outputs four_op_I=1, four_op_sec_I=1, and fnum/block/keyon from the holding register. fb/con/outen still come from its own memory.
- Rhythm (rhy_en=1, bank 0, channels 6..8):
  - keyon_I is taken from rhy_kon instead of memory: ch6 both ops = BD; ch7 op0 = HH, op1 = SD; ch8 op0 = TOM, op1 = CY.
  - con_I is forced to 1 for ch7/ch8.
  - Four-op pairing is unaffected (ch6..8 are never in a pair).
- Simultaneous events:
  - A commit and capture in the same cen: the capture sees the pre-write value; the new value appears next frame.
  - rhy_en toggling takes effect on the next slot.

Test Plan:
- Reset then 36 cen, BANKS=2 -> zero high only at cen 0 and cen 36; bank=1 at slots 18..35; all data outputs 0.
- Write B0 (wr_ch=4, bank=1, din=8'h2D) -> busy for ≤36 cen, single wr_ack; at ch4/bank1 slots keyon_I=1, block_I=3, fnum_I[9:8]=2'b01.
- Mask din=8'h01; ch0 fnum=10'h155, block=5, kon=1; ch3 fnum=0 -> ch3 slots show four_op_sec_I=1, fnum_I=10'h155, block_I=5, keyon_I=1.
- rhy_en=1, rhy_kon=5'b01001 (SD, HH) -> ch7 op0 and op1 keyon_I=1; ch6/ch8 keyon_I=0; ch7 con_I=1.
- wr_ch=4'd12 -> wr_ack on the next clk, memory unchanged.
- Second wr_req while busy is ignored.
- rst low mid-pending -> no wr_ack; busy=0 after release.
